divisor_secuencial_n: RTL
=========================

Name: divisor_secuencial_n

Overview:
- Parametrised sequential restoring divider. It is the next-generation arithmetic core behind the keypad/seven-segment divider top.
- Computes Q = A / B and R = A % B for WIDTH-bit unsigned operands, one quotient bit per clock.
- Uses a valid/ready handshake on both the operand side and the result side.
- Detects divide-by-zero and holds the result until it is consumed. The display/keypad top sits upstream of the operand port and downstream of the result port.

Parameters:
- WIDTH, 8, operand, quotient and remainder width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- op_valid  in  1  A/B operands presented.
- op_ready  out  1  block accepts operands; high only in IDLE.
- a_in  in  WIDTH  dividend.
- b_in  in  WIDTH  divisor.
- res_valid  out  1  quotient/remainder valid; held until accepted.
- res_ready  in  1  consumer accepts the result.
- q_out  out  WIDTH  quotient.
- r_out  out  WIDTH  remainder.
- div_zero  out  1  result came from b_in == 0; qualified by res_valid.
- busy  out  1  high in CALC.

Behaviour:
- Reset (rst low at a clk edge):
  - state = IDLE; op_ready = 1; res_valid = 0; busy = 0; div_zero = 0.
  - q_out, r_out, internal partial remainder and counter all = 0.
  - Reset overrides everything, including mid-CALC: the operation is abandoned and no result is produced.
- FSM states: IDLE, CALC, HOLD.
- IDLE:
  - op_valid && op_ready at an edge latches a_in into the quotient shift register, latches b_in, clears the partial remainder and loads the counter with WIDTH.
  - If b_in != 0: next state CALC.
  - If b_in == 0: next state HOLD with q_out = all ones, r_out = a_in, div_zero = 1. Latency is 1 edge.
- CALC, one restoring step per edge:
  - Form the trial value {P[WIDTH-1:0], Qmsb} - B, computed at WIDTH+1 bits.
  - If the trial value is non-negative: P takes the trial value and a 1 is shifted into Q. Otherwise P takes the shifted value and a 0 is shifted into Q.
  - The counter decrements; when it reaches 0 the next state is HOLD.
  - Latency: res_valid is high in the cycle after the WIDTH-th CALC edge, i.e. WIDTH+1 edges after the accepting edge.
- HOLD:
  - res_valid = 1; q_out, r_out and div_zero are stable and must not change while res_valid && !res_ready.
  - res_valid && res_ready at an edge: next state IDLE, res_valid = 0, div_zero = 0. q_out/r_out keep their values.
- Simultaneous events:
  - An op_valid arriving on the same edge as the result is consumed is not accepted, because op_ready is low in HOLD. Throughput is therefore one division per WIDTH+2 cycles minimum.
  - op_valid and operand changes outside IDLE are ignored.
- Boundary results:
  - A < B gives Q = 0, R = A.
  - B = 1 gives Q = A, R = 0.
  - A = 0 gives Q = 0, R = 0.
  - All widths are exact; no overflow is possible in unsigned mode.

Optional Feature:
- Macro: DIVISOR_SIGNED_EN.
- When defined:
  - Adds input signed_mode (1 bit), sampled at operand acceptance.
  - With signed_mode = 1, operands are two's complement. Magnitudes are taken at load and the same CALC sequence runs, so latency is unchanged.
  - In the HOLD transition, Q is negated if the operand signs differ and R takes the dividend's sign. Quotient truncates toward zero.
  - Adds output ovf (1 bit, qualified by res_valid). For -2^(WIDTH-1) / -1: Q = -2^(WIDTH-1), R = 0, ovf = 1.
  - Signed divide-by-zero: Q = all ones, R = a_in, div_zero = 1.
- When undefined: signed_mode and ovf do not exist, and the block is unsigned-only.

Decomposition:
- Shared package divisor_pkg holds:
  - the state enum (IDLE/CALC/HOLD), 2-bit encoding;
  - the localparam for the divide-by-zero quotient pattern (all ones);
  - a function for the two's-complement magnitude, used only under DIVISOR_SIGNED_EN.
- One natural sub-module: divisor_paso, a purely combinational single restoring step.
  - Inputs: P, Qmsb, B.
  - Outputs: next P and the quotient bit.
  - Parametrised by WIDTH and instantiated once in the CALC datapath.

Test Plan:
- WIDTH=8, A=0x45, B=0x07, res_ready=1 -> res_valid rises 9 edges after acceptance; Q=0x09, R=0x06, div_zero=0.
- WIDTH=8, A=0x2A, B=0x00 -> res_valid after 1 edge; Q=0xFF, R=0x2A, div_zero=1; busy never high.
- WIDTH=8, back-to-back A=0x03/B=0x10, then A=0xFF/B=0x01, with res_ready low for 5 cycles in HOLD:
  - results stable while held, op_ready=0, second op_valid ignored until IDLE;
  - Q=0x00/R=0x03, then Q=0xFF/R=0x00.
- WIDTH=8, rst pulled low on the 4th CALC edge of A=0x80/B=0x03 -> all outputs return to reset values, no res_valid.
  - A fresh A=0x80/B=0x03 then gives Q=0x2A, R=0x02.
- WIDTH=16, A=0xFFFF, B=0x0100 -> res_valid 17 edges after acceptance; Q=0x00FF, R=0x00FF.
- DIVISOR_SIGNED_EN, WIDTH=8, signed_mode=1:
  - A=0xBB (-69), B=0x07 -> Q=0xF7 (-9), R=0xFA (-6).
  - A=0x80, B=0xFF -> Q=0x80, R=0x00, ovf=1.

Source files
------------

// File: rtl/divisor_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// No timing behaviour of its own. No handshake.
// DIVISOR_SIGNED_EN is the only user of mag_c2.
package divisor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Divide-by-zero quotient; sliced down to the operand width at the use site.
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    // Two's-complement magnitude when neg is set; the caller truncates to its width.
    function automatic logic [31:0] mag_c2(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/divisor_paso.sv
// One restoring division step: shift in the next dividend bit and try to subtract B.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the step is registered.
module divisor_paso #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] p,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // P < B always holds, so the trial value's top bit is a clean borrow flag.
    always_comb begin
        shifted = {p, q_msb};
        trial   = shifted - {1'b0, b};
        q_bit   = ~trial[WIDTH];
        p_next  = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/divisor_secuencial_n.sv
// Sequential restoring divider, one quotient bit per clk; DIVISOR_SIGNED_EN adds signed mode.
// Latency: WIDTH+1 edges from operand acceptance to res_valid (1 edge for divide-by-zero).
// Backpressure: op_ready only in IDLE; result held in HOLD until res_ready.
module divisor_secuencial_n
    import divisor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] r_out,
    output logic             div_zero,
`ifdef DIVISOR_SIGNED_EN
    input  logic             signed_mode,
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] p_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;
    logic             div_zero_r;

    logic [WIDTH-1:0] step_p;
    logic             step_q;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic [WIDTH-1:0] a_load;
    logic [WIDTH-1:0] b_load;
    logic             accept;
    logic             last_step;

`ifdef DIVISOR_SIGNED_EN
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic neg_q_r;
    logic neg_r_r;
    logic ovf_r;
`endif

    divisor_paso #(.WIDTH(WIDTH)) u_paso (
        .p      (p_reg),
        .q_msb  (q_reg[WIDTH-1]),
        .b      (b_reg),
        .p_next (step_p),
        .q_bit  (step_q)
    );

    assign accept    = op_valid && op_ready;
    assign last_step = (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (op_valid) state_nxt = (b_in == '0) ? HOLD : CALC;
            CALC: if (last_step) state_nxt = HOLD;
            HOLD: if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        op_ready  = (state == IDLE);
        busy      = (state == CALC);
        res_valid = (state == HOLD);
    end

    // Operand magnitudes at load and sign fix-up on the last step; identity when unsigned.
    always_comb begin
`ifdef DIVISOR_SIGNED_EN
        a_load = WIDTH'(mag_c2(32'(a_in), signed_mode & a_in[WIDTH-1]));
        b_load = WIDTH'(mag_c2(32'(b_in), signed_mode & b_in[WIDTH-1]));
        q_fin  = WIDTH'(mag_c2(32'({q_reg[WIDTH-2:0], step_q}), neg_q_r));
        r_fin  = WIDTH'(mag_c2(32'(step_p), neg_r_r));
`else
        a_load = a_in;
        b_load = b_in;
        q_fin  = {q_reg[WIDTH-2:0], step_q};
        r_fin  = step_p;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_reg      <= '0;
            p_reg      <= '0;
            b_reg      <= '0;
            cnt        <= '0;
            q_res      <= '0;
            r_res      <= '0;
            div_zero_r <= 1'b0;
`ifdef DIVISOR_SIGNED_EN
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            ovf_r      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        q_reg      <= a_load;
                        b_reg      <= b_load;
                        p_reg      <= '0;
                        cnt        <= CNT_W'(WIDTH);
                        div_zero_r <= (b_in == '0);
`ifdef DIVISOR_SIGNED_EN
                        neg_q_r    <= signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                        neg_r_r    <= signed_mode & a_in[WIDTH-1];
                        ovf_r      <= signed_mode && (a_in == MIN_NEG) && (b_in == '1);
`endif
                        if (b_in == '0) begin
                            q_res <= DIV_ZERO_Q[WIDTH-1:0];
                            r_res <= a_in;
                        end
                    end
                end
                CALC: begin
                    p_reg <= step_p;
                    q_reg <= {q_reg[WIDTH-2:0], step_q};
                    cnt   <= cnt - CNT_W'(1);
                    if (last_step) begin
                        q_res <= q_fin;
                        r_res <= r_fin;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        div_zero_r <= 1'b0;
`ifdef DIVISOR_SIGNED_EN
                        ovf_r      <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign q_out    = q_res;
    assign r_out    = r_res;
    assign div_zero = div_zero_r;
`ifdef DIVISOR_SIGNED_EN
    assign ovf      = ovf_r;
`endif

endmodule
